// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: repeat-state encoding,
// default cycle counts for a 50 MHz clock and the pin polarity helper.
package btn_pkg;

  // Hold-to-repeat state per button.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // 20 ms debounce window at 50 MHz.
  localparam int DEF_DB_CYCLES        = 1_000_000;
  // 500 ms before the first repeat at 50 MHz.
  localparam int DEF_RPT_DELAY_CYCLES = 25_000_000;
  // 100 ms between repeats at 50 MHz.
  localparam int DEF_RPT_RATE_CYCLES  = 5_000_000;

  // Map a raw pin level onto "1 = pressed" regardless of board wiring.
  function automatic logic norm_pressed(input logic raw, input logic active_low);
    logic pressed;
    if (active_low) begin
      pressed = ~raw;
    end else begin
      pressed = raw;
    end
    return pressed;
  endfunction

endpackage : btn_pkg

// File: rtl/btn_debounce_chan.sv
// One button channel: polarity normalization, 2-flop synchronizer,
// debounce counter with press/release strobes and, when
// BTN_DEBOUNCE_REPEAT_EN is defined, the hold-to-repeat FSM.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int DB_CYCLES        = DEF_DB_CYCLES,
  parameter bit ACTIVE_LOW       = 1'b1
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  parameter int RPT_DELAY_CYCLES = DEF_RPT_DELAY_CYCLES,
  parameter int RPT_RATE_CYCLES  = DEF_RPT_RATE_CYCLES
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ch_raw,
  output logic ch_level,
  output logic ch_press,
  output logic ch_release
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  output logic ch_repeat
`endif
);

  // A one-cycle window still needs a 1-bit counter that stays at zero.
  localparam int               CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             pressed_s;
  logic [1:0]       sync_r;
  logic             samp_s;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             press_r;
  logic             release_r;
  logic             accept_s;
  logic             acc_press_s;
  logic             acc_release_s;

  assign pressed_s = norm_pressed(ch_raw, ACTIVE_LOW);
  assign samp_s    = sync_r[1];

  // Two-flop synchronizer for the asynchronous pin; resets to "released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], pressed_s};
    end
  end

  // A change is accepted on the DB_CYCLES-th consecutive differing sample.
  always_comb begin
    accept_s      = 1'b0;
    acc_press_s   = 1'b0;
    acc_release_s = 1'b0;
    if ((samp_s != stable_r) && (cnt_r == DB_LAST)) begin
      accept_s      = 1'b1;
      acc_press_s   = samp_s;
      acc_release_s = ~samp_s;
    end else begin
      accept_s      = 1'b0;
      acc_press_s   = 1'b0;
      acc_release_s = 1'b0;
    end
  end

  // Debounce counter, accepted level and registered one-cycle strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_r  <= 1'b0;
      cnt_r     <= '0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      press_r   <= acc_press_s;
      release_r <= acc_release_s;
      if (samp_s == stable_r) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        stable_r <= samp_s;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign ch_level   = stable_r;
  assign ch_press   = press_r;
  assign ch_release = release_r;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int               RPT_MAX   = (RPT_DELAY_CYCLES > RPT_RATE_CYCLES) ?
                                           RPT_DELAY_CYCLES : RPT_RATE_CYCLES;
  localparam int               TMR_W     = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [TMR_W-1:0] DLY_LAST  = TMR_W'(RPT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] RATE_LAST = TMR_W'(RPT_RATE_CYCLES - 1);

  rpt_state_e       rpt_state_r;
  logic [TMR_W-1:0] tmr_r;
  logic             repeat_r;

  // Repeat FSM follows the accept events directly so its timer starts on the
  // same edge the press strobe is registered; a release always wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_state_r <= RPT_IDLE;
      tmr_r       <= '0;
      repeat_r    <= 1'b0;
    end else begin
      repeat_r <= 1'b0;
      if (acc_release_s) begin
        rpt_state_r <= RPT_IDLE;
        tmr_r       <= '0;
      end else begin
        case (rpt_state_r)
          RPT_IDLE: begin
            tmr_r <= '0;
            if (acc_press_s) begin
              rpt_state_r <= RPT_DELAY;
            end else begin
              rpt_state_r <= RPT_IDLE;
            end
          end
          RPT_DELAY: begin
            if (tmr_r == DLY_LAST) begin
              repeat_r    <= 1'b1;
              tmr_r       <= '0;
              rpt_state_r <= RPT_REPEAT;
            end else begin
              tmr_r <= tmr_r + TMR_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (tmr_r == RATE_LAST) begin
              repeat_r <= 1'b1;
              tmr_r    <= '0;
            end else begin
              tmr_r <= tmr_r + TMR_W'(1);
            end
          end
          default: begin
            rpt_state_r <= RPT_IDLE;
            tmr_r       <= '0;
          end
        endcase
      end
    end
  end

  assign ch_repeat = repeat_r;
`endif

endmodule : btn_debounce_chan

// File: rtl/btn_debounce.sv
// Push-button synchronizer/debouncer for the alarm-clock board. Presents
// clean pressed levels to the button PIO plus one-cycle press/release
// strobes. Define BTN_DEBOUNCE_REPEAT_EN to add hold-to-repeat strobes.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN            = 3,
  parameter int DB_CYCLES        = DEF_DB_CYCLES,
  parameter bit ACTIVE_LOW       = 1'b1,
  parameter int RPT_DELAY_CYCLES = DEF_RPT_DELAY_CYCLES,
  parameter int RPT_RATE_CYCLES  = DEF_RPT_RATE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  output logic [N_BTN-1:0] btn_repeat
`endif
);

  // Buttons are fully independent; one channel per pin.
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DB_CYCLES        (DB_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW)
`ifdef BTN_DEBOUNCE_REPEAT_EN
      ,
      .RPT_DELAY_CYCLES (RPT_DELAY_CYCLES),
      .RPT_RATE_CYCLES  (RPT_RATE_CYCLES)
`endif
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .ch_raw     (btn_raw[i]),
      .ch_level   (btn_level[i]),
      .ch_press   (btn_press[i]),
      .ch_release (btn_release[i])
`ifdef BTN_DEBOUNCE_REPEAT_EN
      ,
      .ch_repeat  (btn_repeat[i])
`endif
    );
  end

endmodule : btn_debounce
